// File: rtl/keypad_pkg.sv
// Shared keypad types, widths and helpers.
package keypad_pkg;

  localparam int unsigned ROW_W = 4;
  localparam int unsigned COL_W = 4;

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2
  } kp_state_e;

  // True when exactly one of the four bits is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_DIV clocks.
module keypad_tick_gen #(
  parameter int unsigned CLK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == CNT_MAX);

  // Count 0..CLK_DIV-1 and wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with press/release debounce and a one-shot press strobe.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [COL_W-1:0] col_in,
  output logic [ROW_W-1:0] row_drive,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             key_valid,
  output logic             key_press
);

  localparam int unsigned CNT_W   = 4;
  localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE);

  logic             tick;
  logic [COL_W-1:0] sync1_q, sync2_q;
  kp_state_e        state_q, state_d;
  // row_drive_q doubles as the candidate row while debouncing or held.
  logic [ROW_W-1:0] row_drive_q, row_drive_d;
  logic [COL_W-1:0] cand_col_q, cand_col_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             valid_q, valid_d;
  logic             press_q, press_d;
  logic [ROW_W-1:0] row_rot;
  logic [CNT_W-1:0] match_inc, rel_inc;

  keypad_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchroniser for the asynchronous column lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= col_in;
      sync2_q <= sync1_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SCAN;
      row_drive_q <= ROW_W'(1);
      cand_col_q  <= '0;
      match_cnt_q <= '0;
      rel_cnt_q   <= '0;
      row_q       <= '0;
      col_q       <= '0;
      valid_q     <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_drive_q <= row_drive_d;
      cand_col_q  <= cand_col_d;
      match_cnt_q <= match_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      valid_q     <= valid_d;
      press_q     <= press_d;
    end
  end

  // Next-state logic; everything except the divider only moves on a tick.
  always_comb begin
    state_d     = state_q;
    row_drive_d = row_drive_q;
    cand_col_d  = cand_col_q;
    match_cnt_d = match_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    valid_d     = valid_q;
    press_d     = 1'b0;
    row_rot     = {row_drive_q[ROW_W-2:0], row_drive_q[ROW_W-1]};
    match_inc   = match_cnt_q + CNT_W'(1);
    rel_inc     = rel_cnt_q + CNT_W'(1);

    if (tick) begin
      unique case (state_q)
        S_SCAN: begin
          if (is_onehot4(sync2_q)) begin
            cand_col_d  = sync2_q;
            match_cnt_d = CNT_W'(1);
            if (DEBOUNCE == 1) begin
              row_d   = row_drive_q;
              col_d   = sync2_q;
              valid_d = 1'b1;
              press_d = 1'b1;
              state_d = S_HELD;
            end else begin
              state_d = S_DEBOUNCE;
            end
          end else begin
            row_drive_d = row_rot;
          end
        end
        S_DEBOUNCE: begin
          if (sync2_q == cand_col_q) begin
            match_cnt_d = match_inc;
            if (match_inc == DEB_CNT) begin
              row_d   = row_drive_q;
              col_d   = cand_col_q;
              valid_d = 1'b1;
              press_d = 1'b1;
              state_d = S_HELD;
            end
          end else begin
            match_cnt_d = '0;
            row_drive_d = row_rot;
            state_d     = S_SCAN;
          end
        end
        S_HELD: begin
          if (sync2_q == cand_col_q) begin
            rel_cnt_d = '0;
          end else if (rel_inc == DEB_CNT) begin
            row_d       = '0;
            col_d       = '0;
            valid_d     = 1'b0;
            rel_cnt_d   = '0;
            row_drive_d = row_rot;
            state_d     = S_SCAN;
          end else begin
            rel_cnt_d = rel_inc;
          end
        end
        default: state_d = S_SCAN;
      endcase
    end
  end

  assign row_drive = row_drive_q;
  assign row       = row_q;
  assign col       = col_q;
  assign key_valid = valid_q;
  assign key_press = press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised and directed bench for keypad_scanner against a per-tick keypad model.
module tb_keypad_scanner;

  localparam int CLK_DIV  = 4;
  localparam int DEBOUNCE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_in = 4'd0;
  logic [3:0] row_drive, row, col;
  logic       key_valid, key_press;

  keypad_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk       (clk),
    .rst       (rst),
    .col_in    (col_in),
    .row_drive (row_drive),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_press (key_press)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int dut_presses = 0;

  // Physical keypad: bit r*4+c set means the key at row r, column c is down.
  logic [15:0] keys = 16'd0;

  // Reference model: scan position as a row index, mode 0=looking, 1=confirming, 2=held.
  int m_div, m_scan, m_mode, m_streak, m_miss;
  logic [3:0] m_s1, m_s2, m_cand;
  logic [3:0] e_row, e_col;
  logic       e_valid, e_press;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_accept();
    e_row   = 4'(1 << m_scan);
    e_col   = m_cand;
    e_valid = 1'b1;
    e_press = 1'b1;
    m_mode  = 2;
    m_miss  = 0;
  endtask

  // Advance the model across one clock edge given the pre-edge inputs.
  task automatic model_edge(input logic r, input logic [3:0] c);
    logic       tk;
    logic [3:0] smp;
    if (r) begin
      m_div = 0; m_scan = 0; m_mode = 0; m_streak = 0; m_miss = 0;
      m_s1 = 0; m_s2 = 0; m_cand = 0;
      e_row = 0; e_col = 0; e_valid = 0; e_press = 0;
      return;
    end
    tk    = (m_div == CLK_DIV - 1);
    smp   = m_s2;
    m_div = tk ? 0 : m_div + 1;
    m_s2  = m_s1;
    m_s1  = c;
    e_press = 1'b0;
    if (!tk) return;
    case (m_mode)
      0: begin
        if ($countones(smp) == 1) begin
          m_cand = smp; m_streak = 1;
          if (DEBOUNCE == 1) m_accept(); else m_mode = 1;
        end else m_scan = (m_scan + 1) % 4;
      end
      1: begin
        if (smp == m_cand) begin
          m_streak++;
          if (m_streak == DEBOUNCE) m_accept();
        end else begin
          m_streak = 0; m_scan = (m_scan + 1) % 4; m_mode = 0;
        end
      end
      default: begin
        if (smp == m_cand) m_miss = 0;
        else begin
          m_miss++;
          if (m_miss == DEBOUNCE) begin
            e_row = 0; e_col = 0; e_valid = 0; m_miss = 0;
            m_scan = (m_scan + 1) % 4; m_mode = 0;
          end
        end
      end
    endcase
  endtask

  // One clock: edge, model update, compare, then drive the keypad's column response.
  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    model_edge(r, col_in);
    #1;
    if (key_press === 1'b1) dut_presses++;
    check("row_drive", row_drive, 4'(1 << m_scan));
    check("row", row, e_row);
    check("col", col, e_col);
    check("key_valid", {3'b0, key_valid}, {3'b0, e_valid});
    check("key_press", {3'b0, key_press}, {3'b0, e_press});
    col_in = keys[m_scan*4 +: 4];
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  function automatic logic [15:0] key_bit(input int r, input int c);
    return 16'(1) << (r * 4 + c);
  endfunction

  int p0;

  initial begin
    // Reset and idle scan
    step(1'b1);
    step(1'b1);
    check("rst_row_drive", row_drive, 4'b0001);
    check("rst_row", row, 4'b0000);
    check("rst_valid", {3'b0, key_valid}, 4'd0);
    run(40);

    // Clean press of row 1 / column 2, held for 20 ticks, then released
    p0 = dut_presses;
    keys = key_bit(1, 2);
    run(20 * CLK_DIV + 40);
    check("held_row", row, 4'b0010);
    check("held_col", col, 4'b0100);
    check("held_presses", 4'(dut_presses - p0), 4'd1);
    keys = 16'd0;
    run(8 * CLK_DIV);
    check("rel_valid", {3'b0, key_valid}, 4'd0);

    // Bounce during confirmation, then a stable press with a short release glitch
    keys = key_bit(2, 1);
    for (int i = 0; i < 200 && !(m_mode == 1 && m_streak == 1); i++) step(1'b0);
    run(CLK_DIV);
    keys = 16'd0;
    run(2 * CLK_DIV);
    keys = key_bit(2, 1);
    run(12 * CLK_DIV);
    p0 = dut_presses;
    keys = 16'd0;
    run(2 * CLK_DIV);
    keys = key_bit(2, 1);
    run(10 * CLK_DIV);
    check("glitch_valid", {3'b0, key_valid}, 4'd1);
    check("glitch_presses", 4'(dut_presses - p0), 4'd0);

    // Two columns on one row are ignored; a second key while held acts as release
    keys = key_bit(0, 0) | key_bit(0, 2);
    run(16 * CLK_DIV);
    keys = key_bit(3, 3);
    run(12 * CLK_DIV);
    keys = key_bit(3, 3) | key_bit(3, 0);
    run(8 * CLK_DIV);
    check("multi_rel_valid", {3'b0, key_valid}, 4'd0);
    keys = 16'd0;
    run(8 * CLK_DIV);

    // Reset two matching ticks into confirmation discards the press
    p0 = dut_presses;
    keys = key_bit(0, 3);
    for (int i = 0; i < 200 && !(m_mode == 1 && m_streak == 2); i++) step(1'b0);
    step(1'b1);
    check("mid_rst_valid", {3'b0, key_valid}, 4'd0);
    check("mid_rst_presses", 4'(dut_presses - p0), 4'd0);
    run(12 * CLK_DIV);
    check("re_press_presses", 4'(dut_presses - p0), 4'd1);
    keys = 16'd0;
    run(8 * CLK_DIV);

    // Random keypad activity with occasional reset
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(3, 0))
        0: keys = 16'd0;
        1, 2: keys = key_bit($urandom_range(3, 0), $urandom_range(3, 0));
        default: keys = key_bit($urandom_range(3, 0), $urandom_range(3, 0)) |
                        key_bit($urandom_range(3, 0), $urandom_range(3, 0));
      endcase
      if ($urandom_range(14, 0) == 0) step(1'b1);
      run($urandom_range(60, 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
